// File: rtl/fp_add_sub_arb_pkg.sv
// Shared types and defaults for the fp_add_sub arbiter: tag pipeline stage and unit mode encoding.
package fp_add_sub_arb_pkg;

  localparam int unsigned NUM_REQ_DEF     = 4;
  localparam int unsigned TAG_W_DEF       = 2;
  localparam int unsigned FPU_LATENCY_DEF = 7;

  // Stage tag is sized for the largest supported requester count (8).
  localparam int unsigned TAG_W_MAX = 3;

  localparam logic FPU_MODE_ADD = 1'b1;
  localparam logic FPU_MODE_SUB = 1'b0;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
  } tag_stage_t;

  function automatic logic fpu_mode(input logic sub);
    return sub ? FPU_MODE_SUB : FPU_MODE_ADD;
  endfunction

endpackage

// File: rtl/fp_add_sub_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after prio_ptr, wrapping.
module fp_add_sub_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   prio_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   grant_idx
);

  logic [TAG_W:0]   sum;
  logic [TAG_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // prio_ptr < NUM_REQ, so a single conditional subtract wraps the index.
      sum = {1'b0, prio_ptr} + (TAG_W + 1)'(k);
      if (sum >= (TAG_W + 1)'(NUM_REQ)) begin
        sum = sum - (TAG_W + 1)'(NUM_REQ);
      end
      idx = sum[TAG_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fp_add_sub_arbiter.sv
// Shares one pipelined fp_add_sub unit among NUM_REQ requesters; a tag pipeline running in
// lockstep with the unit routes each result back to its issuer.
module fp_add_sub_arbiter
  import fp_add_sub_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter int unsigned FPU_LATENCY = FPU_LATENCY_DEF,
  parameter int unsigned TAG_W       = TAG_W_DEF
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  clk_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_dataa,
  input  logic [32*NUM_REQ-1:0] req_datab,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic [31:0]           fpu_dataa,
  output logic [31:0]           fpu_datab,
  output logic                  fpu_add_sub,
  input  logic [31:0]           fpu_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_result
);

  logic [TAG_W-1:0]   prio_ptr;
  logic [TAG_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic               handshake;

  logic [31:0] sel_dataa;
  logic [31:0] sel_datab;
  logic        sel_sub;

  tag_stage_t stage0;
  tag_stage_t tag_pipe [FPU_LATENCY];
  tag_stage_t tag_last;

  logic [NUM_REQ-1:0] rsp_onehot;

  fp_add_sub_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_rr (
    .req       (req_valid),
    .prio_ptr  (prio_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // No backpressure from the unit: any enabled, non-reset cycle can accept one op.
  assign req_ready = grant & {NUM_REQ{clk_en & ~aclr}};
  assign handshake = |req_ready;

  assign next_ptr = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_dataa = '0;
    sel_datab = '0;
    sel_sub   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_dataa = sel_dataa | (req_dataa[32*i +: 32] & {32{grant[i]}});
      sel_datab = sel_datab | (req_datab[32*i +: 32] & {32{grant[i]}});
      sel_sub   = sel_sub | (req_sub[i] & grant[i]);
    end
  end

  // Issue stage and round-robin pointer.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      prio_ptr    <= '0;
      fpu_dataa   <= '0;
      fpu_datab   <= '0;
      fpu_add_sub <= FPU_MODE_ADD;
      stage0      <= '0;
    end else if (clk_en) begin
      if (handshake) begin
        prio_ptr     <= next_ptr;
        fpu_dataa    <= sel_dataa;
        fpu_datab    <= sel_datab;
        fpu_add_sub  <= fpu_mode(sel_sub);
        stage0.valid <= 1'b1;
        stage0.tag   <= TAG_W_MAX'(grant_idx);
      end else begin
        stage0.valid <= 1'b0;
      end
    end
  end

  // Tag pipeline: tag_pipe[FPU_LATENCY-1] lines up with fpu_result.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < FPU_LATENCY; k++) begin
        tag_pipe[k] <= '0;
      end
    end else if (clk_en) begin
      tag_pipe[0] <= stage0;
      for (int k = 1; k < FPU_LATENCY; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign tag_last = tag_pipe[FPU_LATENCY-1];

  always_comb begin
    rsp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_onehot[i] = tag_last.valid && (tag_last.tag == TAG_W_MAX'(i));
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
    end else if (clk_en) begin
      rsp_valid  <= rsp_onehot;
      rsp_result <= fpu_result;
    end
  end

endmodule
